sm3_msg_arb: RTL
================

# sm3_msg_arb

Two-requester, message-granular arbiter that shares one SM3 pad/expand/compress pipeline. It grants one requester, forwards its word stream to the pipeline until the last word, then waits for the 256-bit digest and routes it back to the granted requester. Round-robin priority keeps both requesters served. Sits between the two SM3 clients and the input of the SM3 pad stage; the digest comes back from the compression core's result output.

## Interface
Parameters:
- DW, 32, message word width in bits (multiple of 8)
- RES_W, 256, digest width
- TMO_CYC, 1024, result watchdog limit in cycles (used only with SM3_ARB_TMO_EN)

Ports:
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req0_vld_i / req1_vld_i  in  1  requester word valid
- req0_rdy_o / req1_rdy_o  out  1  requester word ready
- req0_data_i / req1_data_i  in  DW  message word
- req0_lst_i / req1_lst_i  in  1  last word of message
- req0_bvld_i / req1_bvld_i  in  DW/8  valid-byte mask of the word (MSB-aligned)
- core_vld_o  out  1  word valid to pipeline
- core_rdy_i  in  1  pipeline ready
- core_data_o  out  DW, core_lst_o  out  1, core_bvld_o  out  DW/8  forwarded word fields
- core_res_i  in  RES_W  digest from compression core
- core_res_vld_i  in  1  digest valid, 1-cycle pulse
- res_o  out  RES_W  registered digest
- res_vld_o  out  2  one-hot, 1-cycle pulse; bit n is the digest for requester n
- busy_o  out  1  high in STREAM or WAIT_RES
- gnt_o  out  1  index of the current/last grant
- tmo_err_o  out  1  watchdog pulse (0 when SM3_ARB_TMO_EN is off)

## Operation
- States: IDLE, STREAM, WAIT_RES.
- IDLE: both reqN_rdy_o = 0, core_vld_o = 0.
  - If exactly one reqN_vld_i is high, grant n.
  - If both are high, grant the requester indicated by priority pointer ptr.
  - Register gnt, go to STREAM. No word is consumed in IDLE.
- STREAM, combinational pass-through from the granted requester g:
  - core_vld_o = reqg_vld_i; core_data/lst/bvld_o = reqg fields.
  - reqg_rdy_o = core_rdy_i; the other requester's rdy = 0.
  - Handshake = core_vld_o & core_rdy_i. A handshake with core_lst_o = 1 moves to WAIT_RES.
- WAIT_RES: no forwarding.
  - On core_res_vld_i: res_o <= core_res_i, res_vld_o[g] <= 1 for one cycle, ptr <= ~g, go to IDLE.
- core_res_vld_i outside WAIT_RES is ignored; res_o is unchanged.
- While not in STREAM, core_data_o/core_lst_o/core_bvld_o drive 0.
- Grant is held for the whole message. A requester deasserting vld mid-message stalls the pipeline; it does not release the grant.

## Timing
- Reset values: state IDLE, ptr 0, gnt_o 0, res_o 0, res_vld_o 0, busy_o 0, tmo_err_o 0, all rdy 0, core_vld_o 0.
- Request seen in IDLE at cycle t → STREAM at t+1 → first word can be forwarded at t+1.
- Forwarding latency is 0 cycles: data, valid and ready are combinational, giving full throughput of one word per cycle.
- Last-word handshake at cycle t → WAIT_RES at t+1.
- core_res_vld_i at cycle t → res_vld_o pulse and res_o valid at t+1, state IDLE at t+1.
- The next grant is decided at t+1 and its STREAM starts at t+2.
- A single-word message (lst on the first word) is legal.
- Reset asserted mid-message: immediate return to reset values; a partial message is discarded. The SM3 pipeline shares rst_n and is cleared with it.

## Configuration
- SM3_ARB_TMO_EN defined:
  - A 16-bit counter clears on entry to WAIT_RES and increments each cycle in WAIT_RES.
  - When it reaches TMO_CYC-1 with no core_res_vld_i: tmo_err_o pulses 1 cycle, no res_vld_o, ptr <= ~g, state IDLE.
  - core_res_vld_i in that same cycle takes precedence (normal completion, no error).
- SM3_ARB_TMO_EN undefined: no counter; WAIT_RES waits indefinitely; tmo_err_o is tied to 0.

## Test plan
- Single requester: req0 sends "abc" (one word 0x61626300, bvld 4'b1110, lst); core model returns 66c7f0f4…8f4ba8e0 → res_vld_o = 2'b01 with res_o equal to that digest, one cycle after the core pulse.
- Both requesters request simultaneously from reset → req0 granted first (ptr 0), req1 second; res_vld_o pulses 01 then 10; gnt_o is 0 then 1.
- Back-to-back contention over 4 messages per requester → strict alternation of grants; neither requester is starved.
- Backpressure: core_rdy_i toggles every other cycle during a 16-word message → exactly 16 handshakes, word order preserved, and req1 rdy stays 0 throughout.
- Reset asserted in the middle of a STREAM word 5 → all outputs return to reset values immediately; a new message after reset completes correctly.
- With SM3_ARB_TMO_EN and TMO_CYC = 8, no core result → tmo_err_o pulses exactly 8 cycles after entry to WAIT_RES; res_vld_o stays 0; the next grant goes to the other requester.

Source files
------------

// File: rtl/sm3_msg_arb.sv
// Two-requester, message-granular round-robin arbiter in front of a shared SM3 pipeline.
// Optional result watchdog enabled by defining SM3_ARB_TMO_EN.
module sm3_msg_arb #(
    parameter int DW      = 32,
    parameter int RES_W   = 256,
    parameter int TMO_CYC = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_vld_i,
    output logic              req0_rdy_o,
    input  logic [DW-1:0]     req0_data_i,
    input  logic              req0_lst_i,
    input  logic [DW/8-1:0]   req0_bvld_i,
    input  logic              req1_vld_i,
    output logic              req1_rdy_o,
    input  logic [DW-1:0]     req1_data_i,
    input  logic              req1_lst_i,
    input  logic [DW/8-1:0]   req1_bvld_i,
    output logic              core_vld_o,
    input  logic              core_rdy_i,
    output logic [DW-1:0]     core_data_o,
    output logic              core_lst_o,
    output logic [DW/8-1:0]   core_bvld_o,
    input  logic [RES_W-1:0]  core_res_i,
    input  logic              core_res_vld_i,
    output logic [RES_W-1:0]  res_o,
    output logic [1:0]        res_vld_o,
    output logic              busy_o,
    output logic              gnt_o,
    output logic              tmo_err_o
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_WAIT   = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_gnt;
    logic               w_gnt_nxt;
    logic               r_ptr;
    logic               w_ptr_nxt;
    logic [RES_W-1:0]   r_res;
    logic [1:0]         r_res_vld;
    logic               w_done;
    logic               w_tmo;

`ifdef SM3_ARB_TMO_EN
    logic [15:0]        r_cnt;
    logic               r_tmo;

    // Counter sits at zero outside WAIT_RES, so it is cleared on entry.
    assign w_tmo = (r_state == S_WAIT) && (r_cnt == 16'(TMO_CYC - 1)) && !core_res_vld_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_tmo <= 1'b0;
        end else begin
            r_tmo <= w_tmo;
            if (r_state != S_WAIT)
                r_cnt <= '0;
            else
                r_cnt <= r_cnt + 16'd1;
        end
    end

    assign tmo_err_o = r_tmo;
`else
    assign w_tmo     = 1'b0;
    assign tmo_err_o = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_ptr_nxt   = r_ptr;
        w_done      = 1'b0;
        req0_rdy_o  = 1'b0;
        req1_rdy_o  = 1'b0;
        core_vld_o  = 1'b0;
        core_data_o = '0;
        core_lst_o  = 1'b0;
        core_bvld_o = '0;
        case (r_state)
            S_IDLE: begin
                if (req0_vld_i || req1_vld_i) begin
                    w_gnt_nxt   = (req0_vld_i && req1_vld_i) ? r_ptr : req1_vld_i;
                    w_state_nxt = S_STREAM;
                end
            end
            S_STREAM: begin
                // Zero-latency pass-through; grant is held even if vld drops.
                if (r_gnt) begin
                    core_vld_o  = req1_vld_i;
                    core_data_o = req1_data_i;
                    core_lst_o  = req1_lst_i;
                    core_bvld_o = req1_bvld_i;
                    req1_rdy_o  = core_rdy_i;
                end else begin
                    core_vld_o  = req0_vld_i;
                    core_data_o = req0_data_i;
                    core_lst_o  = req0_lst_i;
                    core_bvld_o = req0_bvld_i;
                    req0_rdy_o  = core_rdy_i;
                end
                if (core_vld_o && core_rdy_i && core_lst_o)
                    w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (core_res_vld_i) begin
                    w_done      = 1'b1;
                    w_ptr_nxt   = ~r_gnt;
                    w_state_nxt = S_IDLE;
                end else if (w_tmo) begin
                    w_ptr_nxt   = ~r_gnt;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_gnt     <= 1'b0;
            r_ptr     <= 1'b0;
            r_res     <= '0;
            r_res_vld <= 2'b00;
        end else begin
            r_state   <= w_state_nxt;
            r_gnt     <= w_gnt_nxt;
            r_ptr     <= w_ptr_nxt;
            r_res_vld <= w_done ? (r_gnt ? 2'b10 : 2'b01) : 2'b00;
            if (w_done)
                r_res <= core_res_i;
        end
    end

    assign res_o     = r_res;
    assign res_vld_o = r_res_vld;
    assign busy_o    = (r_state != S_IDLE);
    assign gnt_o     = r_gnt;

endmodule
